// File: rtl/spike_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_fetch_sequencer_if
// Description : Bundle of spike inputs, read-address outputs and returned-
//               data framing flags for the spike fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface spike_fetch_sequencer_if #(
  parameter int N_SRC  = 30,
  parameter int ADDR_W = 10
);
  localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic              boot_mode;
  logic [N_SRC-1:0]  spike_in;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic [ID_W-1:0]   src_id;
  logic              is_bias;
  logic              data_start;
  logic              data_last;
  logic              data_done;
  logic              busy;
  logic              merge_err;

  // Sequencer side: consumes spikes, drives the memory read port
  modport master (
    input  boot_mode, spike_in,
    output addr, addr_valid, src_id, is_bias,
           data_start, data_last, data_done, busy, merge_err
  );

  // Environment side: produces spikes, observes the read port
  modport slave (
    output boot_mode, spike_in,
    input  addr, addr_valid, src_id, is_bias,
           data_start, data_last, data_done, busy, merge_err
  );
endinterface
`default_nettype wire

// File: rtl/spike_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spike_fetch_sequencer
// Description : Latches spike events into a sticky pending mask, arbitrates
//               among them (fixed priority or round-robin) and emits one
//               burst of consecutive read addresses per grant. A bias burst
//               is issued first on boot. Framing flags are delayed by the
//               memory read latency to line up with returned data.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_fetch_sequencer #(
  parameter int N_SRC      = 30,
  parameter int WORDS      = 2,
  parameter int STRIDE     = 2,
  parameter int ADDR_W     = 10,
  parameter int BIAS_BASE  = 60,
  parameter int BIAS_WORDS = 2,
  parameter int RD_LAT     = 1,
  parameter int ARB_RR     = 0
) (
  input  wire logic               clk,
  input  wire logic               rst,
  spike_fetch_sequencer_if.master bus
);
  localparam int ID_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int EXT_W   = ADDR_W + 8;
  localparam int MAX_LEN = (WORDS > BIAS_WORDS) ? WORDS : BIAS_WORDS;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              boot_req_q, boot_req_d;
  logic              boot_mode_prev_q;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_idx_q, last_idx_d;
  logic              addr_valid_q, addr_valid_d;
  logic [ID_W-1:0]   src_id_q, src_id_d;
  logic              is_bias_q, is_bias_d;
  logic [RD_LAT:0]   start_pipe_q, start_pipe_d;
  logic [RD_LAT:0]   last_pipe_q, last_pipe_d;
  logic              data_done_q, data_done_d;
  logic              merge_err_q, merge_err_d;

  logic              w_gnt_found;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [ID_W-1:0]   w_cand;
  logic              w_take_bias;
  logic              w_take_src;
  logic [N_SRC-1:0]  w_gnt_mask;
  logic              w_first;
  logic              w_last;

  // Arbiter: scan from ptr (round-robin) or from 0 (fixed priority), first set bit wins
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ARB_RR != 0) w_cand = ID_W'((int'(ptr_q) + i) % N_SRC);
      else             w_cand = ID_W'(i);
      if (!w_gnt_found && pend_q[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  // Bias request beats any spike; a grant only happens from IDLE
  assign w_take_bias = (state_q == S_IDLE) && boot_req_q;
  assign w_take_src  = (state_q == S_IDLE) && !boot_req_q && w_gnt_found;
  assign w_gnt_mask  = w_take_src ? (N_SRC'(1) << w_gnt_idx) : '0;

  // Next-state logic for the burst FSM, pending mask and framing pipes
  always_comb begin
    state_d      = state_q;
    pend_d       = (pend_q & ~w_gnt_mask) | bus.spike_in;
    ptr_d        = ptr_q;
    boot_req_d   = (boot_req_q & ~w_take_bias) | (bus.boot_mode & ~boot_mode_prev_q);
    base_d       = base_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    last_idx_d   = last_idx_q;
    addr_valid_d = addr_valid_q;
    src_id_d     = src_id_q;
    is_bias_d    = is_bias_q;
    w_first      = 1'b0;
    w_last       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_take_bias || w_take_src) begin
          // Granting registers word 0 immediately so bursts chain without a bubble
          base_d       = w_take_bias ? ADDR_W'(BIAS_BASE)
                                     : ADDR_W'(EXT_W'(w_gnt_idx) * EXT_W'(STRIDE));
          addr_d       = base_d;
          addr_valid_d = 1'b1;
          src_id_d     = w_take_bias ? '0 : w_gnt_idx;
          is_bias_d    = w_take_bias;
          last_idx_d   = w_take_bias ? CNT_W'(BIAS_WORDS - 1) : CNT_W'(WORDS - 1);
          cnt_d        = CNT_W'(1);
          w_first      = 1'b1;
          if (last_idx_d == '0) begin
            w_last  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_BURST;
          end
          if (w_take_src) begin
            ptr_d = (w_gnt_idx == ID_W'(N_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;
          end
        end else begin
          addr_valid_d = 1'b0;
        end
      end
      S_BURST: begin
        addr_d       = ADDR_W'(EXT_W'(base_q) + EXT_W'(cnt_q));
        addr_valid_d = 1'b1;
        if (cnt_q == last_idx_q) begin
          w_last  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_pipe_d = {start_pipe_q[RD_LAT-1:0], w_first};
    last_pipe_d  = {last_pipe_q[RD_LAT-1:0], w_last};
    data_done_d  = last_pipe_q[RD_LAT];
    merge_err_d  = |(bus.spike_in & pend_q & ~w_gnt_mask);
  end

  // State registers; reset aborts any burst and drops in-flight framing flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      pend_q           <= '0;
      ptr_q            <= '0;
      boot_req_q       <= 1'b0;
      boot_mode_prev_q <= 1'b0;
      base_q           <= '0;
      addr_q           <= '0;
      cnt_q            <= '0;
      last_idx_q       <= '0;
      addr_valid_q     <= 1'b0;
      src_id_q         <= '0;
      is_bias_q        <= 1'b0;
      start_pipe_q     <= '0;
      last_pipe_q      <= '0;
      data_done_q      <= 1'b0;
      merge_err_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_q           <= pend_d;
      ptr_q            <= ptr_d;
      boot_req_q       <= boot_req_d;
      boot_mode_prev_q <= bus.boot_mode;
      base_q           <= base_d;
      addr_q           <= addr_d;
      cnt_q            <= cnt_d;
      last_idx_q       <= last_idx_d;
      addr_valid_q     <= addr_valid_d;
      src_id_q         <= src_id_d;
      is_bias_q        <= is_bias_d;
      start_pipe_q     <= start_pipe_d;
      last_pipe_q      <= last_pipe_d;
      data_done_q      <= data_done_d;
      merge_err_q      <= merge_err_d;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.src_id     = src_id_q;
  assign bus.is_bias    = is_bias_q;
  assign bus.data_start = start_pipe_q[RD_LAT];
  assign bus.data_last  = last_pipe_q[RD_LAT];
  assign bus.data_done  = data_done_q;
  assign bus.merge_err  = merge_err_q;
  assign bus.busy       = (state_q == S_BURST) | addr_valid_q | (|pend_q) | boot_req_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_fetch_sequencer
// Description : Directed, table-driven bench for spike_fetch_sequencer using
//               three instances: default, round-robin, and single-word with
//               a three-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_fetch_sequencer;
  logic clk;
  logic rst0, rst1, rst2;
  int   n_cmp;
  int   n_err;

  spike_fetch_sequencer_if #(.N_SRC(30), .ADDR_W(10)) if0 ();
  spike_fetch_sequencer_if #(.N_SRC(30), .ADDR_W(10)) if1 ();
  spike_fetch_sequencer_if #(.N_SRC(30), .ADDR_W(10)) if2 ();

  spike_fetch_sequencer u0 (.clk(clk), .rst(rst0), .bus(if0));
  spike_fetch_sequencer #(.ARB_RR(1)) u1 (.clk(clk), .rst(rst1), .bus(if1));
  spike_fetch_sequencer #(.WORDS(1), .RD_LAT(3)) u2 (.clk(clk), .rst(rst2), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;
    int          boot;
    logic [29:0] spike;
    int          addr;
    int          av;
    int          src;
    int          bias;
    int          ds;
    int          dl;
    int          dd;
    int          busy;
    int          merr;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input int r, input int boot, input logic [29:0] spike,
                              input int addr, input int av, input int src, input int bias,
                              input int ds, input int dl, input int dd,
                              input int busy, input int merr);
    vec_t v;
    v.r = r; v.boot = boot; v.spike = spike; v.addr = addr; v.av = av; v.src = src;
    v.bias = bias; v.ds = ds; v.dl = dl; v.dd = dd; v.busy = busy; v.merr = merr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input int addr, input int av, input int src,
                      input int bias, input int ds, input int dl, input int dd,
                      input int busy, input int merr);
    chk({tag, " addr"},       int'(if0.addr),       addr);
    chk({tag, " addr_valid"}, int'(if0.addr_valid), av);
    chk({tag, " src_id"},     int'(if0.src_id),     src);
    chk({tag, " is_bias"},    int'(if0.is_bias),    bias);
    chk({tag, " data_start"}, int'(if0.data_start), ds);
    chk({tag, " data_last"},  int'(if0.data_last),  dl);
    chk({tag, " data_done"},  int'(if0.data_done),  dd);
    chk({tag, " busy"},       int'(if0.busy),       busy);
    chk({tag, " merge_err"},  int'(if0.merge_err),  merr);
  endtask

  initial begin
    logic [6:0] exp_ds;
    logic [6:0] exp_dd;
    n_cmp = 0;
    n_err = 0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.boot_mode = 1'b0; if0.spike_in = '0;
    if1.boot_mode = 1'b0; if1.spike_in = '0;
    if2.boot_mode = 1'b0; if2.spike_in = '0;

    //              rst boot spike          addr av src bias ds dl dd busy merr
    tbl[0]  = mk(1, 1, 30'h0,           0, 0, 0, 0,  0, 0, 0,  0, 0);
    tbl[1]  = mk(0, 1, 30'h0,           0, 0, 0, 0,  0, 0, 0,  1, 0);
    tbl[2]  = mk(0, 1, 30'h0,          60, 1, 0, 1,  0, 0, 0,  1, 0);
    tbl[3]  = mk(0, 1, 30'h0,          61, 1, 0, 1,  1, 0, 0,  1, 0);
    tbl[4]  = mk(0, 0, 30'h88,         61, 0, 0, 1,  0, 1, 0,  1, 0);
    tbl[5]  = mk(0, 0, 30'h0,           6, 1, 3, 0,  0, 0, 1,  1, 0);
    tbl[6]  = mk(0, 0, 30'h0,           7, 1, 3, 0,  1, 0, 0,  1, 0);
    tbl[7]  = mk(0, 0, 30'h0,          14, 1, 7, 0,  0, 1, 0,  1, 0);
    tbl[8]  = mk(0, 0, 30'h0,          15, 1, 7, 0,  1, 0, 1,  1, 0);
    tbl[9]  = mk(0, 0, 30'h0,          15, 0, 7, 0,  0, 1, 0,  0, 0);
    tbl[10] = mk(0, 0, 30'h0,          15, 0, 7, 0,  0, 0, 1,  0, 0);
    tbl[11] = mk(0, 0, 30'h21,         15, 0, 7, 0,  0, 0, 0,  1, 0);
    tbl[12] = mk(0, 0, 30'h20,          0, 1, 0, 0,  0, 0, 0,  1, 1);
    tbl[13] = mk(0, 0, 30'h0,           1, 1, 0, 0,  1, 0, 0,  1, 0);
    tbl[14] = mk(0, 0, 30'h20,         10, 1, 5, 0,  0, 1, 0,  1, 0);
    tbl[15] = mk(0, 0, 30'h0,          11, 1, 5, 0,  1, 0, 1,  1, 0);
    tbl[16] = mk(0, 0, 30'h0,          10, 1, 5, 0,  0, 1, 0,  1, 0);
    tbl[17] = mk(0, 0, 30'h0,          11, 1, 5, 0,  1, 0, 1,  1, 0);
    tbl[18] = mk(0, 0, 30'h0,          11, 0, 5, 0,  0, 1, 0,  0, 0);
    tbl[19] = mk(0, 0, 30'h0,          11, 0, 5, 0,  0, 0, 1,  0, 0);

    step();
    step();

    // Boot bias burst, fixed-priority spikes, merge and same-cycle requeue
    for (int i = 0; i < 20; i++) begin
      rst0          = tbl[i].r[0];
      if0.boot_mode = tbl[i].boot[0];
      if0.spike_in  = tbl[i].spike;
      step();
      chk0($sformatf("row%0d", i), tbl[i].addr, tbl[i].av, tbl[i].src, tbl[i].bias,
           tbl[i].ds, tbl[i].dl, tbl[i].dd, tbl[i].busy, tbl[i].merr);
    end

    // Reset during the second word of a burst
    if0.spike_in = 30'h4;
    step();
    chk("rst pend busy", int'(if0.busy), 1);
    if0.spike_in = 30'h0;
    step();
    chk("rst word0 addr", int'(if0.addr), 4);
    chk("rst word0 src", int'(if0.src_id), 2);
    if0.spike_in = 30'h200;
    step();
    chk("rst word1 addr", int'(if0.addr), 5);
    chk("rst word1 valid", int'(if0.addr_valid), 1);
    if0.spike_in = 30'h0;
    rst0 = 1'b1;
    step();
    chk0("in_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst%0d data_last", k), int'(if0.data_last), 0);
      chk($sformatf("post_rst%0d data_done", k), int'(if0.data_done), 0);
      chk($sformatf("post_rst%0d busy", k), int'(if0.busy), 0);
    end
    if0.spike_in = 30'h1;
    step();
    if0.spike_in = 30'h0;
    step();
    chk("after_rst addr0", int'(if0.addr), 0);
    chk("after_rst valid0", int'(if0.addr_valid), 1);
    step();
    chk("after_rst addr1", int'(if0.addr), 1);
    chk("after_rst valid1", int'(if0.addr_valid), 1);

    // Round-robin: 29, 0, 29, 0, 29 with pointer wrap
    rst1 = 1'b0;
    step();
    if1.spike_in = 30'h2000_0000;
    step();
    chk("rr pend busy", int'(if1.busy), 1);
    if1.spike_in = 30'h2000_0001;
    step();
    chk("rr g1 src", int'(if1.src_id), 29);
    chk("rr g1 addr", int'(if1.addr), 58);
    if1.spike_in = 30'h0;
    step();
    chk("rr g1 addr1", int'(if1.addr), 59);
    chk("rr requeue merge", int'(if1.merge_err), 0);
    if1.spike_in = 30'h1;
    step();
    chk("rr g2 src", int'(if1.src_id), 0);
    chk("rr g2 addr", int'(if1.addr), 0);
    if1.spike_in = 30'h0;
    step();
    chk("rr g2 addr1", int'(if1.addr), 1);
    if1.spike_in = 30'h2000_0000;
    step();
    chk("rr g3 src", int'(if1.src_id), 29);
    chk("rr g3 addr", int'(if1.addr), 58);
    if1.spike_in = 30'h0;
    step();
    chk("rr g3 addr1", int'(if1.addr), 59);
    step();
    chk("rr g4 src wrap", int'(if1.src_id), 0);
    chk("rr g4 addr", int'(if1.addr), 0);
    step();
    step();
    chk("rr g5 src", int'(if1.src_id), 29);
    step();
    step();
    chk("rr end valid", int'(if1.addr_valid), 0);
    chk("rr end busy", int'(if1.busy), 0);

    // Single-word bursts with three-cycle read latency
    rst2 = 1'b0;
    step();
    if2.spike_in = 30'h50;
    step();
    if2.spike_in = 30'h0;
    exp_ds = 7'b0011000;
    exp_dd = 7'b0110000;
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 0) begin
        chk("w1 addr0", int'(if2.addr), 8);
        chk("w1 src0", int'(if2.src_id), 4);
      end
      if (k == 1) begin
        chk("w1 addr1", int'(if2.addr), 12);
        chk("w1 src1", int'(if2.src_id), 6);
      end
      chk($sformatf("w1 e%0d valid", k + 1), int'(if2.addr_valid), (k < 2) ? 1 : 0);
      chk($sformatf("w1 e%0d data_start", k + 1), int'(if2.data_start), int'(exp_ds[k]));
      chk($sformatf("w1 e%0d data_last", k + 1), int'(if2.data_last), int'(exp_ds[k]));
      chk($sformatf("w1 e%0d data_done", k + 1), int'(if2.data_done), int'(exp_dd[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spike_fetch_sequencer.md
# spike_fetch_sequencer

Parametrised spike-driven address sequencer for the synaptic/bias memory read port. It latches spike events from `N_SRC` neurons into a sticky pending mask and arbitrates among them with a fixed-priority or round-robin policy. For each grant it emits a burst of `WORDS` consecutive read addresses, and on boot it issues a dedicated bias burst first. Read-data framing flags are delayed by the memory read latency so downstream accumulators can align to returned data.

## Interface
Parameters:
- `N_SRC`, 30: number of spike sources (neurons).
- `WORDS`, 2: addresses per burst, ≥1.
- `STRIDE`, 2: address step between neuron blocks, ≥`WORDS`.
- `ADDR_W`, 10: address width.
- `BIAS_BASE`, 60: first bias address.
- `BIAS_WORDS`, 2: bias burst length, ≥1.
- `RD_LAT`, 1: memory read latency in cycles, ≥1.
- `ARB_RR`, 0: 0 = lowest index wins; 1 = round-robin.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `boot_mode` in 1: request bias fetch.
- `spike_in` in `N_SRC`: per-neuron spike pulses, any number per cycle.
- `addr` out `ADDR_W`: read address.
- `addr_valid` out 1: `addr` is a live read.
- `src_id` out `$clog2(N_SRC)`: neuron of current burst; 0 during bias bursts.
- `is_bias` out 1: current burst is the bias burst.
- `data_start` out 1: first returned word of a burst.
- `data_last` out 1: last returned word.
- `data_done` out 1: one-cycle pulse after `data_last`.
- `busy` out 1: burst in progress or requests pending.
- `merge_err` out 1: pulse when a spike hits an already-pending, not-being-granted neuron.

## Operation
- Pending mask: `pend <= (pend & ~grant_mask) | spike_in`. A spike on a neuron in the same cycle that neuron is granted re-queues it.
- `merge_err`: asserted for one cycle when `spike_in[i] & pend[i] & ~grant_mask[i]` for any `i`. The events merge.
- Boot request: `boot_req` is set on the first cycle after reset deassertion if `boot_mode=1`, and on any `boot_mode` 0→1 edge. It is cleared when the bias burst is granted. The bias burst has priority over all spikes.
- FSM states:
  - IDLE: if `boot_req`, start the bias burst with base=`BIAS_BASE`. Else if `pend≠0`, grant one neuron `g` with base=`g*STRIDE`. Else `addr_valid<=0`.
  - BURST: `addr <= base + cnt` with `cnt` running 1..len-1. On the last word, go to IDLE.
  - With `len=1`, go straight to IDLE.
- Granting in IDLE registers `addr=base`, `addr_valid=1`, `src_id`, `is_bias`, and clears the granted bit. Consecutive bursts are therefore back-to-back with no bubble.
- Arbitration:
  - `ARB_RR=0`: lowest set index wins.
  - `ARB_RR=1`: first set index at or after `ptr`, wrapping at `N_SRC`. After each grant, `ptr <= g+1`, or 0 if `g=N_SRC-1`.
- Address arithmetic is computed at `ADDR_W+8` bits and truncated to `ADDR_W`. Overflow wraps silently; `N_SRC*STRIDE ≤ 2^ADDR_W` is the integrator's responsibility.
- `src_id`, `is_bias` and `addr` hold their values while `addr_valid=0`.
- `busy = (state==BURST) | addr_valid | (pend≠0) | boot_req`.

## Timing
- Reset values: `addr=0`, `addr_valid=0`, `src_id=0`, `is_bias=0`, `data_start=0`, `data_last=0`, `data_done=0`, `merge_err=0`. Internally `pend=0`, `ptr=0`, `boot_req=0`, state=IDLE, delay pipes cleared.
- Reset mid-burst: the burst is aborted immediately. No `data_done` is produced for it, and pending spikes are lost.
- Latency:
  - `spike_in` sampled at edge E0.
  - First `addr` valid after E1, i.e. 2 cycles from spike to address when idle.
  - Word k is valid after edge E1+k.
- Data flags are `RD_LAT`-cycle delayed copies of the first-word and last-word address markers.
  - `data_start` is high RD_LAT cycles after the first address.
  - `data_last` is high RD_LAT cycles after the last address. For `WORDS=1`, `data_start` and `data_last` are high in the same cycle.
  - `data_done` is high the cycle after `data_last`, and may overlap the next burst's `data_start`.
- `merge_err` is registered and appears the cycle after the offending spike.

## Test plan
- Default params; reset, then `boot_mode=1`:
  - `addr` = 60, 61 with `is_bias=1` in the 2nd and 3rd cycles after reset release.
  - `data_start` one cycle after addr 60.
  - `data_last` with returned word 61.
  - `data_done` on the next cycle.
- `spike_in` = bits 3 and 7 in one cycle, `ARB_RR=0`:
  - Addresses are 6, 7, 14, 15 back-to-back with `addr_valid` continuously high.
  - `src_id` = 3 then 7.
  - `busy` falls after the last word.
- `ARB_RR=1`, grant 29 first, then hold bits 0 and 29 pending, pulsing 29 each grant → grants alternate 0, 29, 0 (wrap-around); the pointer wraps 29→0.
- Spike bit 5 twice while it is pending → one `merge_err` pulse, one burst (10, 11). Spike bit 5 in the same cycle it is granted → a second burst (10, 11) follows, with no `merge_err`.
- Assert `rst` during the second word of a burst:
  - All outputs are 0 the next cycle.
  - No `data_done` is produced for the aborted burst.
  - A later spike on bit 0 produces addresses 0, 1.
- `WORDS=1`, `RD_LAT=3` → `data_start` and `data_last` coincide 3 cycles after each address, and `data_done` follows 1 cycle later.
